// File: rtl/pc_control_unit.sv
// pc_control_unit: program counter plus instruction decoder and branch-target LUT.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (clears prog_ctr only)
//   mach_code    9-bit instruction word; op = mach_code[8:4], LUT index = mach_code[3:0]
//   branch_flag  registered ALU flag qualifying conditional branches
//   reljump_en   relative-jump request (prog_ctr + target)
//   prog_ctr     current program counter (registered)
//   target       LUT branch target, 16 * mach_code[3:0] (combinational)
//   absjump      taken absolute branch = BranchInst & branch_flag (combinational)
//   InstType     00 R-type, 01 I-type, 11 move-immediate
//   BranchInst, MemRead, MemWrite, ALUSrc, RegWrite, MemtoReg, ALUOp
//                datapath controls decoded combinationally from op
module pc_control_unit #(
    parameter int unsigned D = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [8:0]   mach_code,
    input  logic         branch_flag,
    input  logic         reljump_en,
    output logic [D-1:0] prog_ctr,
    output logic [D-1:0] target,
    output logic         absjump,
    output logic [1:0]   InstType,
    output logic         BranchInst,
    output logic         MemRead,
    output logic         MemWrite,
    output logic         ALUSrc,
    output logic         RegWrite,
    output logic         MemtoReg,
    output logic [3:0]   ALUOp
);

    localparam int unsigned OP_W  = 5;
    localparam int unsigned IDX_W = 4;

    localparam logic [OP_W-1:0] OP_LOAD   = 5'b01000;
    localparam logic [OP_W-1:0] OP_STORE  = 5'b01001;
    localparam logic [OP_W-1:0] OP_BRANCH = 5'b01010;

    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] lut_idx;
    logic [D-1:0]     pc_next;

    assign op      = mach_code[8:4];
    assign lut_idx = mach_code[3:0];

    // Instruction decoder; op[4:3] selects the instruction class.
    always_comb begin
        InstType   = 2'b00;
        BranchInst = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUOp      = 4'b1111;

        unique case (op[4:3])
            2'b00: begin
                // R-type: low opcode bits pass straight through as the ALU function
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = {1'b0, op[2:0]};
            end
            2'b01: begin
                if (op == OP_LOAD) begin
                    MemRead  = 1'b1;
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    ALUSrc   = 1'b1;
                    ALUOp    = 4'b1000;
                end else if (op == OP_STORE) begin
                    MemWrite = 1'b1;
                    ALUSrc   = 1'b1;
                    ALUOp    = 4'b1000;
                end else if (op == OP_BRANCH) begin
                    BranchInst = 1'b1;
                end
                // remaining 01xxx codes are reserved and decode as NOP
            end
            2'b10: begin
                // I-type: op[2:0] are register bits, not function bits
                InstType = 2'b01;
                RegWrite = 1'b1;
                ALUOp    = 4'b0000;
            end
            default: begin
                InstType = 2'b11;
                RegWrite = 1'b1;
            end
        endcase
    end

    // Branch-target LUT: entry n is 16*n.
    assign target = D'({lut_idx, 4'b0000});

    assign absjump = BranchInst & branch_flag;

    // Next PC; absolute jump has priority over relative jump. Sums wrap modulo 2^D.
    always_comb begin
        pc_next = prog_ctr + D'(1);
        if (absjump) begin
            pc_next = target;
        end else if (reljump_en) begin
            pc_next = prog_ctr + target;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_ctr <= '0;
        end else begin
            prog_ctr <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: directed scenarios plus random instructions checked
// against an arithmetic reference model of the decoder, LUT and program counter.
module tb_pc_control_unit;

    localparam int unsigned D      = 12;
    localparam int unsigned PC_MOD = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic [8:0]   mach_code;
    logic         branch_flag;
    logic         reljump_en;
    logic [D-1:0] prog_ctr;
    logic [D-1:0] target;
    logic         absjump;
    logic [1:0]   InstType;
    logic         BranchInst;
    logic         MemRead;
    logic         MemWrite;
    logic         ALUSrc;
    logic         RegWrite;
    logic         MemtoReg;
    logic [3:0]   ALUOp;

    int          checks = 0;
    int          errors = 0;
    int unsigned model_pc = 0;

    pc_control_unit #(.D(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .mach_code  (mach_code),
        .branch_flag(branch_flag),
        .reljump_en (reljump_en),
        .prog_ctr   (prog_ctr),
        .target     (target),
        .absjump    (absjump),
        .InstType   (InstType),
        .BranchInst (BranchInst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .ALUOp      (ALUOp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (mach_code=%b pc_model=%0d)",
                   tag, obs, exp, mach_code, model_pc);
        end
    endtask

    // Reference decode, LUT and branch outputs for the present inputs.
    task automatic check_comb();
        int unsigned opv, idx;
        int unsigned e_type, e_br, e_mr, e_mw, e_src, e_rw, e_m2r, e_alu;
        opv = 32'(mach_code[8:4]);
        idx = 32'(mach_code[3:0]);
        e_type = 0; e_br = 0; e_mr = 0; e_mw = 0; e_src = 0; e_rw = 0; e_m2r = 0; e_alu = 15;
        if (opv < 8) begin
            e_rw = 1; e_src = 1; e_alu = opv;
        end else if (opv == 8) begin
            e_mr = 1; e_m2r = 1; e_rw = 1; e_src = 1; e_alu = 8;
        end else if (opv == 9) begin
            e_mw = 1; e_src = 1; e_alu = 8;
        end else if (opv == 10) begin
            e_br = 1;
        end else if (opv >= 16 && opv < 24) begin
            e_type = 1; e_rw = 1; e_alu = 0;
        end else if (opv >= 24) begin
            e_type = 3; e_rw = 1;
        end
        chk("InstType",   32'(InstType),   e_type);
        chk("BranchInst", 32'(BranchInst), e_br);
        chk("MemRead",    32'(MemRead),    e_mr);
        chk("MemWrite",   32'(MemWrite),   e_mw);
        chk("ALUSrc",     32'(ALUSrc),     e_src);
        chk("RegWrite",   32'(RegWrite),   e_rw);
        chk("MemtoReg",   32'(MemtoReg),   e_m2r);
        chk("ALUOp",      32'(ALUOp),      e_alu);
        chk("target",     32'(target),     16 * idx);
        chk("absjump",    32'(absjump),    (opv == 10 && branch_flag) ? 1 : 0);
    endtask

    // Drive one instruction (called just after a rising edge), check, clock, check PC.
    task automatic apply(input logic [8:0] mc, input logic bf, input logic rel);
        int unsigned opv, idx;
        mach_code   = mc;
        branch_flag = bf;
        reljump_en  = rel;
        #1;
        check_comb();
        opv = 32'(mc[8:4]);
        idx = 32'(mc[3:0]);
        if (opv == 10 && bf)
            model_pc = 16 * idx;
        else if (rel)
            model_pc = (model_pc + 16 * idx) % PC_MOD;
        else
            model_pc = (model_pc + 1) % PC_MOD;
        @(posedge clk);
        #1;
        chk("prog_ctr", 32'(prog_ctr), model_pc);
    endtask

    // Walk the PC forward to goal using relative jumps and NOPs.
    task automatic goto_pc(input int unsigned goal);
        int unsigned diff, step;
        for (int n = 0; n < 400 && model_pc != goal; n++) begin
            diff = (goal + PC_MOD - model_pc) % PC_MOD;
            if (diff >= 16) begin
                step = (diff / 16 > 15) ? 15 : diff / 16;
                apply({5'b01011, 4'(step)}, 1'b0, 1'b1);
            end else begin
                apply(9'b0_1011_0000, 1'b0, 1'b0);
            end
        end
        chk("goto_pc reached", 32'(prog_ctr), goal);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        chk("async reset", 32'(prog_ctr), 0);
        #1;
        reset = 1'b1;
        model_pc = 0;
    endtask

    initial begin
        reset       = 1'b1;
        mach_code   = 9'b0_1011_0000;
        branch_flag = 1'b0;
        reljump_en  = 1'b0;

        // Reset held low: PC cleared and held across an edge
        #1 reset = 1'b0;
        #2;
        chk("reset immediate", 32'(prog_ctr), 0);
        check_comb();
        @(posedge clk);
        #1;
        chk("reset held", 32'(prog_ctr), 0);
        reset = 1'b1;
        model_pc = 0;

        // Count up from 0 with NOPs
        for (int i = 0; i < 3; i++) apply(9'b0_1011_0000, 1'b0, 1'b0);

        // Taken and untaken absolute branch
        apply(9'b0_1010_0101, 1'b1, 1'b0);
        chk("abs jump to 80", 32'(prog_ctr), 80);
        apply(9'b0_1010_0101, 1'b0, 1'b0);
        chk("untaken branch", 32'(prog_ctr), 81);

        // Relative jump from 10 with index 3
        reset_pulse();
        goto_pc(10);
        apply(9'b0_1011_0011, 1'b0, 1'b1);
        chk("rel jump 10+48", 32'(prog_ctr), 58);

        // Relative jump that wraps
        goto_pc(4090);
        apply(9'b0_1011_0001, 1'b0, 1'b1);
        chk("rel jump wrap", 32'(prog_ctr), 10);

        // Increment wrap
        goto_pc(4095);
        apply(9'b0_1011_0000, 1'b0, 1'b0);
        chk("inc wrap", 32'(prog_ctr), 0);

        // Absolute beats relative
        goto_pc(100);
        apply(9'b0_1010_0010, 1'b1, 1'b1);
        chk("abs over rel", 32'(prog_ctr), 32);

        // Reset asserted mid-jump cancels it
        mach_code   = 9'b0_1010_1111;
        branch_flag = 1'b1;
        reljump_en  = 1'b1;
        reset       = 1'b0;
        #1;
        chk("reset mid-jump", 32'(prog_ctr), 0);
        chk("absjump during reset", 32'(absjump), 1);
        chk("target during reset", 32'(target), 240);
        @(posedge clk);
        #1;
        chk("reset cancels jump", 32'(prog_ctr), 0);
        reset = 1'b1;
        model_pc = 0;
        apply(9'b0_1011_0000, 1'b0, 1'b0);

        // Opcode sweep
        for (int o = 0; o < 32; o++)
            apply({5'(o), 4'($urandom_range(0, 15))}, 1'($urandom_range(0, 1)), 1'b0);

        // Random instruction stream
        for (int i = 0; i < 300; i++)
            apply(9'($urandom), 1'($urandom), 1'($urandom));

        // Random asynchronous reset pulses interleaved with traffic
        for (int i = 0; i < 5; i++) begin
            apply(9'($urandom), 1'($urandom), 1'($urandom));
            reset_pulse();
            apply(9'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
